// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared RV32I decode constants and small opcode-classification helpers.
//   Contents:
//     OPC_*     7-bit major opcodes used by the decode/issue stage
//     NOP_INST  canonical bubble instruction (addi x0,x0,0)
//     uses_rs1 / uses_rs2 / writes_rd  opcode classification helpers
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    // Only the U-type and JAL formats have no rs1 field; unknown opcodes are
    // treated as reading rs1 so hazard detection errs on the safe side.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [6:0] opcode);
        return (opcode == OPC_OP    || opcode == OPC_OP_IMM || opcode == OPC_LOAD ||
                opcode == OPC_JAL   || opcode == OPC_JALR   || opcode == OPC_LUI  ||
                opcode == OPC_AUIPC);
    endfunction

endpackage

// File: rtl/decode_issue_stage_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
//   Combinational RV32I immediate generator.
//   Ports:
//     inst  in  32  instruction word
//     imm   out 32  sign-extended immediate selected by opcode (0 if none)
// ---------------------------------------------------------------------------
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    // Pick the immediate format from the major opcode. B and J immediates
    // are halfword offsets, so their bit 0 is always zero.
    always_comb begin
        imm = '0;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {inst[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// ---------------------------------------------------------------------------
// decode_issue_stage
//   RV32I decode/issue stage: reads operands (with writeback bypass),
//   decodes the immediate and destination, detects load-use hazards and
//   loads the ID/EX pipeline register.
//   Ports:
//     clock, reset_n              clock, async active-low reset
//     id_valid, id_pc, id_inst    IF/ID register contents
//     rf_addr_rs1/2, rf_data_rs1/2  register-file read port
//     wb_we, wb_rd, wb_data       writeback port (bypassed into operands)
//     flush                       squash the instruction in ID
//     stall                       hold PC and IF/ID this cycle
//     ex_*                        ID/EX pipeline register
//     perf_stall_cnt              saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module decode_issue_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] NOP_INST = rv32i_pkg::NOP_INST
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_inst,
    output logic [4:0]  rf_addr_rs1,
    output logic [4:0]  rf_addr_rs2,
    input  logic [31:0] rf_data_rs1,
    input  logic [31:0] rf_data_rs2,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_inst,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic        ex_is_load,
    output logic [31:0] perf_stall_cnt
);

    logic [6:0]  opcode;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] imm;
    logic        load_use_hazard;

    assign opcode      = id_inst[6:0];
    assign rs1_addr    = id_inst[19:15];
    assign rs2_addr    = id_inst[24:20];
    assign rf_addr_rs1 = rs1_addr;
    assign rf_addr_rs2 = rs2_addr;

    imm_gen u_imm_gen (
        .inst (id_inst),
        .imm  (imm)
    );

    // Operand read with writeback bypass: the register file is written at
    // the end of this cycle, so a same-cycle writeback to a source register
    // must be forwarded. x0 is hardwired to zero whatever the RF returns.
    always_comb begin
        rs1_value = rf_data_rs1;
        rs2_value = rf_data_rs2;
        if (rs1_addr == 5'd0) begin
            rs1_value = '0;
        end else if (wb_we && wb_rd == rs1_addr) begin
            rs1_value = wb_data;
        end
        if (rs2_addr == 5'd0) begin
            rs2_value = '0;
        end else if (wb_we && wb_rd == rs2_addr) begin
            rs2_value = wb_data;
        end
    end

    // A load in EX has no data until after MEM, so a dependent instruction
    // in ID must wait one cycle. A flush overrides the stall because the ID
    // instruction is being discarded anyway.
    always_comb begin
        load_use_hazard = 1'b0;
        if (id_valid && ex_valid && ex_is_load && ex_rd != 5'd0) begin
            load_use_hazard = (uses_rs1(opcode) && ex_rd == rs1_addr) ||
                              (uses_rs2(opcode) && ex_rd == rs2_addr);
        end
    end

    assign stall = load_use_hazard && !flush;

    // ID/EX register. Flush, stall and an empty IF/ID all insert a bubble;
    // stall already excludes flush, so one condition covers the priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_inst     <= NOP_INST;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_is_load  <= 1'b0;
        end else if (flush || stall || !id_valid) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_inst     <= NOP_INST;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_is_load  <= 1'b0;
        end else begin
            ex_valid    <= 1'b1;
            ex_pc       <= id_pc;
            ex_inst     <= id_inst;
            ex_rs1_data <= rs1_value;
            ex_rs2_data <= rs2_value;
            ex_imm      <= imm;
            ex_rd       <= writes_rd(opcode) ? id_inst[11:7] : 5'd0;
            ex_is_load  <= (opcode == OPC_LOAD);
        end
    end

    // Stall-cycle counter; it sticks at all-ones rather than wrapping so a
    // long run never reports a misleadingly small number.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt <= '0;
        end else if (stall && perf_stall_cnt != 32'hFFFFFFFF) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_issue_stage
//   Self-checking bench for decode_issue_stage: directed pipeline scenarios
//   followed by randomized instruction streams, all compared against a
//   behavioural model of the ID/EX register and stall counter.
// ---------------------------------------------------------------------------
module tb_decode_issue_stage;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_SYS    = 7'h73;
    localparam logic [31:0] NOP      = 32'h00000013;

    localparam logic [31:0] LW_X5_X1   = 32'h0000A283;
    localparam logic [31:0] ADD_X6     = 32'h00228333;
    localparam logic [31:0] ADDI_X7_X3 = 32'h00018393;
    localparam logic [31:0] ADDI_X7_X0 = 32'h00000393;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [4:0]  rf_addr_rs1;
    logic [4:0]  rf_addr_rs2;
    logic [31:0] rf_data_rs1;
    logic [31:0] rf_data_rs2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic [31:0] perf_stall_cnt;

    always #5 clock = ~clock;

    decode_issue_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .rf_addr_rs1    (rf_addr_rs1),
        .rf_addr_rs2    (rf_addr_rs2),
        .rf_data_rs1    (rf_data_rs1),
        .rf_data_rs2    (rf_data_rs2),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .flush          (flush),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_inst        (ex_inst),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_is_load     (ex_is_load),
        .perf_stall_cnt (perf_stall_cnt)
    );

    int checkCount = 0;
    int failCount  = 0;

    // Expected ID/EX contents, stall and counter as the model sees them.
    logic        mValid;
    logic [31:0] mPc;
    logic [31:0] mInst;
    logic [31:0] mRs1;
    logic [31:0] mRs2;
    logic [31:0] mImm;
    logic [4:0]  mRd;
    logic        mIsLoad;
    logic        mStall;
    logic [31:0] mCnt;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic readsRs1(input logic [6:0] op);
        return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic logic readsRs2(input logic [6:0] op);
        return op inside {OP_REG, OP_STORE, OP_BRANCH};
    endfunction

    function automatic logic hasDest(input logic [6:0] op);
        return op inside {OP_REG, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    // Immediate assembled arithmetically from the ISA field layout.
    function automatic logic [31:0] refImm(input logic [31:0] w);
        logic [31:0] sx;
        logic [31:0] r;
        sx = {32{w[31]}};
        r  = 32'd0;
        case (w[6:0])
            OP_IMM, OP_LOAD, OP_JALR: r = (sx << 12) | 32'(w[31:20]);
            OP_STORE:  r = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
            OP_BRANCH: r = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
                           | (32'(w[11:8]) << 1);
            OP_LUI, OP_AUIPC: r = w & 32'hFFFFF000;
            OP_JAL:    r = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
                           | (32'(w[30:21]) << 1);
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] refOperand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_rd == a) return wb_data;
        return rf;
    endfunction

    task automatic modelBubble();
        mValid  = 1'b0;
        mPc     = 32'd0;
        mInst   = NOP;
        mRs1    = 32'd0;
        mRs2    = 32'd0;
        mImm    = 32'd0;
        mRd     = 5'd0;
        mIsLoad = 1'b0;
    endtask

    task automatic modelReset();
        modelBubble();
        mStall = 1'b0;
        mCnt   = 32'd0;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic we, input logic [4:0] rd, input logic [31:0] data,
                                 input logic fl);
        id_valid    = v;
        id_pc       = pc;
        id_inst     = inst;
        rf_data_rs1 = r1;
        rf_data_rs2 = r2;
        wb_we       = we;
        wb_rd       = rd;
        wb_data     = data;
        flush       = fl;
    endtask

    task automatic checkEx(input string tag);
        checkOutput({tag, ":ex_valid"}, 32'(ex_valid), 32'(mValid));
        checkOutput({tag, ":ex_pc"}, ex_pc, mPc);
        checkOutput({tag, ":ex_inst"}, ex_inst, mInst);
        checkOutput({tag, ":ex_rs1_data"}, ex_rs1_data, mRs1);
        checkOutput({tag, ":ex_rs2_data"}, ex_rs2_data, mRs2);
        checkOutput({tag, ":ex_imm"}, ex_imm, mImm);
        checkOutput({tag, ":ex_rd"}, 32'(ex_rd), 32'(mRd));
        checkOutput({tag, ":ex_is_load"}, 32'(ex_is_load), 32'(mIsLoad));
        checkOutput({tag, ":perf_stall_cnt"}, perf_stall_cnt, mCnt);
    endtask

    // Called just after a falling edge with inputs applied: checks the
    // combinational outputs, advances the model across the rising edge and
    // checks the registered outputs, returning at the next falling edge.
    task automatic cycleAndCheck(input string tag);
        logic [6:0] op;
        logic [4:0] a1;
        logic [4:0] a2;
        logic       hazard;
        #1;
        op = id_inst[6:0];
        a1 = id_inst[19:15];
        a2 = id_inst[24:20];
        hazard = id_valid && mValid && mIsLoad && (mRd != 5'd0) &&
                 ((readsRs1(op) && mRd == a1) || (readsRs2(op) && mRd == a2));
        mStall = hazard && !flush;
        checkOutput({tag, ":stall"}, 32'(stall), 32'(mStall));
        checkOutput({tag, ":rf_addr_rs1"}, 32'(rf_addr_rs1), 32'(a1));
        checkOutput({tag, ":rf_addr_rs2"}, 32'(rf_addr_rs2), 32'(a2));
        if (mStall && mCnt != 32'hFFFFFFFF) mCnt = mCnt + 32'd1;
        if (flush || mStall || !id_valid) begin
            modelBubble();
        end else begin
            mValid  = 1'b1;
            mPc     = id_pc;
            mInst   = id_inst;
            mRs1    = refOperand(a1, rf_data_rs1);
            mRs2    = refOperand(a2, rf_data_rs2);
            mImm    = refImm(id_inst);
            mRd     = hasDest(op) ? id_inst[11:7] : 5'd0;
            mIsLoad = (op == OP_LOAD);
        end
        @(posedge clock);
        #1;
        checkEx(tag);
        @(negedge clock);
    endtask

    function automatic logic [31:0] randInst();
        logic [6:0]  ops [10];
        logic [31:0] w;
        ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
                OP_REG, OP_IMM, OP_SYS};
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] rinst;

        reset_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        modelReset();
        #12;
        checkEx("reset");
        checkOutput("reset:stall", 32'(stall), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Load followed by a dependent add: one bubble, then the add issues.
        applyStimulus(1'b1, 32'h100, LW_X5_X1, 32'h11, 32'h22, 1'b0, 5'd0, 32'd0, 1'b0);
        cycleAndCheck("lw");
        applyStimulus(1'b1, 32'h104, ADD_X6, 32'h33, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0);
        cycleAndCheck("loaduse");
        checkOutput("loaduse:bubble", 32'(ex_valid), 32'd0);
        checkOutput("loaduse:cnt", perf_stall_cnt, 32'd1);
        checkOutput("reissue:nostall", 32'(stall), 32'd0);
        cycleAndCheck("reissue");
        checkOutput("reissue:inst", ex_inst, ADD_X6);
        checkOutput("reissue:valid", 32'(ex_valid), 32'd1);

        // Writeback bypass into rs1, and x0 ignoring a writeback to x0.
        applyStimulus(1'b1, 32'h108, ADDI_X7_X3, 32'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        cycleAndCheck("wbBypass");
        checkOutput("wbBypass:rs1", ex_rs1_data, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h10C, ADDI_X7_X0, 32'h55, 32'd0, 1'b1, 5'd0, 32'd5, 1'b0);
        cycleAndCheck("x0Read");
        checkOutput("x0Read:rs1", ex_rs1_data, 32'd0);

        // Load-use hazard coinciding with a flush: flush wins, no count.
        applyStimulus(1'b1, 32'h110, LW_X5_X1, 32'h1, 32'h2, 1'b0, 5'd0, 32'd0, 1'b0);
        cycleAndCheck("lw2");
        applyStimulus(1'b1, 32'h114, ADD_X6, 32'h3, 32'h4, 1'b0, 5'd0, 32'd0, 1'b1);
        #1;
        checkOutput("flushStall:stall", 32'(stall), 32'd0);
        cycleAndCheck("flushStall");
        checkOutput("flushStall:valid", 32'(ex_valid), 32'd0);
        checkOutput("flushStall:inst", ex_inst, NOP);
        checkOutput("flushStall:cnt", perf_stall_cnt, 32'd1);

        // Immediate decode: beq x0,x0,-4 and a lui to x0.
        applyStimulus(1'b1, 32'h118, 32'hFE000EE3, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        cycleAndCheck("beq");
        checkOutput("beq:imm", ex_imm, 32'hFFFFFFFC);
        applyStimulus(1'b1, 32'h11C, 32'h12345037, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        cycleAndCheck("lui");
        checkOutput("lui:imm", ex_imm, 32'h12345000);
        checkOutput("lui:rd", 32'(ex_rd), 32'd0);

        // Counter saturation: preload near the top, then two stall cycles.
        applyStimulus(1'b1, 32'h120, LW_X5_X1, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        cycleAndCheck("satLw1");
        force dut.perf_stall_cnt = 32'hFFFFFFFE;
        #1;
        release dut.perf_stall_cnt;
        mCnt = 32'hFFFFFFFE;
        applyStimulus(1'b1, 32'h124, ADD_X6, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        cycleAndCheck("satStall1");
        checkOutput("sat:first", perf_stall_cnt, 32'hFFFFFFFF);
        cycleAndCheck("satReissue");
        applyStimulus(1'b1, 32'h128, LW_X5_X1, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        cycleAndCheck("satLw2");
        applyStimulus(1'b1, 32'h12C, ADD_X6, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        cycleAndCheck("satStall2");
        checkOutput("sat:hold", perf_stall_cnt, 32'hFFFFFFFF);

        // Asynchronous reset asserted in the middle of a stall cycle.
        applyStimulus(1'b1, 32'h130, LW_X5_X1, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        cycleAndCheck("rstLw");
        applyStimulus(1'b1, 32'h134, ADD_X6, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        #2;
        checkOutput("midStall:stall", 32'(stall), 32'd1);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkEx("asyncReset");
        checkOutput("asyncReset:stall", 32'(stall), 32'd0);
        @(posedge clock);
        #1;
        checkEx("heldReset");
        @(negedge clock);
        reset_n = 1'b1;

        // Random stream; a stalled IF/ID entry is re-presented unchanged.
        rv    = 1'b0;
        rpc   = 32'h1000;
        rinst = NOP;
        for (int i = 0; i < 400; i++) begin
            if (!mStall) begin
                rv    = ($urandom_range(0, 99) < 85);
                rpc   = rpc + 32'd4;
                rinst = randInst();
            end
            applyStimulus(rv, rpc, rinst, $urandom, $urandom, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), $urandom,
                          ($urandom_range(0, 99) < 10));
            cycleAndCheck($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
